// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: pc_sel encoding package plus the request/control interface.
// Perf counter signals exist only when FETCH_CTRL_PERF_EN is defined.
package fetch_ctrl_pkg;
  localparam int PC_SEL_WIDTH = 2;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_PLUS_FOUR = 2'd0;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH    = 2'd1;
  localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_STALL     = 2'd2;
endpackage

interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic                    br_taken_exe;
  logic                    stall_req;
  logic                    halt_req;
  logic                    resume;
  logic [PC_SEL_WIDTH-1:0] pc_sel;
  logic                    flush_decode;
  logic                    flush_exe;
  logic                    stall_decode;
  logic                    halted;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]             perf_stall_cnt;
  logic [31:0]             perf_flush_cnt;
  logic [31:0]             perf_redirect_cnt;
`endif

  // Master is the pipeline raising requests; slave is the controller.
  modport master (
    output br_taken_exe, stall_req, halt_req, resume,
    input  pc_sel, flush_decode, flush_exe, stall_decode, halted
`ifdef FETCH_CTRL_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt, perf_redirect_cnt
`endif
  );

  modport slave (
    input  br_taken_exe, stall_req, halt_req, resume,
    output pc_sel, flush_decode, flush_exe, stall_decode, halted
`ifdef FETCH_CTRL_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt, perf_redirect_cnt
`endif
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: reset hold, branch redirect/flush window, halt, load-use stall.
// Optional performance counters are enabled with FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int RESET_HOLD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.slave  fc_if
);

  typedef enum logic [1:0] {HOLD, RUN, FLUSH, HALT} state_t;

  localparam logic [3:0] HOLD_RELOAD  = 4'(RESET_HOLD_CYCLES - 1);
  // The redirect cycle itself is the first flush cycle, so the window reload is one less.
  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [PC_SEL_WIDTH-1:0] pc_sel_d;
  logic                    flush_decode_d, flush_exe_d, stall_decode_d, halted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= HOLD_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_sel_d       = PC_SEL_PLUS_FOUR;
    flush_decode_d = 1'b0;
    flush_exe_d    = 1'b0;
    stall_decode_d = 1'b0;
    halted_d       = 1'b0;
    case (state_q)
      HOLD: begin
        pc_sel_d       = PC_SEL_STALL;
        flush_decode_d = 1'b1;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RUN: begin
        if (fc_if.br_taken_exe) begin
          pc_sel_d       = PC_SEL_BRANCH;
          flush_decode_d = 1'b1;
          flush_exe_d    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (fc_if.halt_req) begin
          pc_sel_d       = PC_SEL_STALL;
          flush_decode_d = 1'b1;
          state_d        = HALT;
        end else if (fc_if.stall_req) begin
          pc_sel_d       = PC_SEL_STALL;
          stall_decode_d = 1'b1;
          flush_exe_d    = 1'b1;
        end
      end
      FLUSH: begin
        flush_decode_d = 1'b1;
        // Halt/stall requests here come from squashed instructions.
        if (fc_if.br_taken_exe) begin
          pc_sel_d    = PC_SEL_BRANCH;
          flush_exe_d = 1'b1;
          cnt_d       = FLUSH_RELOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALT: begin
        pc_sel_d       = PC_SEL_STALL;
        flush_decode_d = 1'b1;
        halted_d       = 1'b1;
        if (fc_if.resume) state_d = RUN;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = HOLD_RELOAD;
      end
    endcase
  end

  assign fc_if.pc_sel       = pc_sel_d;
  assign fc_if.flush_decode = flush_decode_d;
  assign fc_if.flush_exe    = flush_exe_d;
  assign fc_if.stall_decode = stall_decode_d;
  assign fc_if.halted       = halted_d;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_redirect_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q    <= 32'd0;
      perf_flush_q    <= 32'd0;
      perf_redirect_q <= 32'd0;
    end else begin
      if (state_q == RUN && stall_decode_d)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_decode_d && state_q != HOLD && state_q != HALT)
        perf_flush_q <= perf_flush_q + 32'd1;
      if (pc_sel_d == PC_SEL_BRANCH)
        perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign fc_if.perf_stall_cnt    = perf_stall_q;
  assign fc_if.perf_flush_cnt    = perf_flush_q;
  assign fc_if.perf_redirect_cnt = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (FLUSH_CYCLES=3, RESET_HOLD_CYCLES=2): vector table plus
// hand sequences for reset hold, halt/resume and reset during a flush window.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [1:0] P4 = PC_SEL_PLUS_FOUR;
  localparam logic [1:0] BR = PC_SEL_BRANCH;
  localparam logic [1:0] ST = PC_SEL_STALL;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.FLUSH_CYCLES(3), .RESET_HOLD_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic       halt;
    logic       stall;
    logic       resume;
    logic [1:0] pc;
    logic       fd;
    logic       fe;
    logic       sd;
    logic       hl;
  } vec_t;

  vec_t tbl [22];

  task automatic drive(input logic br, input logic halt, input logic stall, input logic resume);
    bus.br_taken_exe = br;
    bus.halt_req     = halt;
    bus.stall_req    = stall;
    bus.resume       = resume;
  endtask

  task automatic check(input string name, input logic [1:0] pc, input logic fd,
                       input logic fe, input logic sd, input logic hl);
    n_vec++;
    if (bus.pc_sel !== pc || bus.flush_decode !== fd || bus.flush_exe !== fe ||
        bus.stall_decode !== sd || bus.halted !== hl) begin
      n_bad++;
      $display("FAIL %s: got pc_sel=%0d fd=%b fe=%b sd=%b halted=%b, required pc_sel=%0d fd=%b fe=%b sd=%b halted=%b",
               name, bus.pc_sel, bus.flush_decode, bus.flush_exe, bus.stall_decode, bus.halted,
               pc, fd, fe, sd, hl);
    end else begin
      $display("ok   %s: pc_sel=%0d fd=%b fe=%b sd=%b halted=%b",
               name, bus.pc_sel, bus.flush_decode, bus.flush_exe, bus.stall_decode, bus.halted);
    end
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic cycle_check(input string name, input logic [1:0] pc, input logic fd,
                             input logic fe, input logic sd, input logic hl);
    @(negedge clk);
    check(name, pc, fd, fe, sd, hl);
    @(posedge clk);
    #1;
  endtask

  task automatic hold_sequence(input string tag);
    cycle_check({tag, " hold0"}, ST, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle_check({tag, " hold1"}, ST, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle_check({tag, " run0"},  P4, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef FETCH_CTRL_PERF_EN
  task automatic check_perf_zero(input string name);
    n_vec++;
    if (bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0 || bus.perf_redirect_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL %s: got stall=%0d flush=%0d redirect=%0d, required all 0",
               name, bus.perf_stall_cnt, bus.perf_flush_cnt, bus.perf_redirect_cnt);
    end else begin
      $display("ok   %s: perf counters all 0", name);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_bad = 0;
    //         br    halt  stall resume pc  fd    fe    sd    hl
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, BR, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, P4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, P4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, BR, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, BR, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, ST, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, ST, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, ST, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, P4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, ST, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, ST, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, P4, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset state", ST, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    check_perf_zero("perf at reset");
`endif
    // Requests during HOLD must be ignored.
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("hold ignores req", ST, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle_check("hold1", ST, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle_check("run0",  P4, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].br, tbl[i].halt, tbl[i].stall, tbl[i].resume);
      cycle_check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fd, tbl[i].fe, tbl[i].sd, tbl[i].hl);
    end

    // Halt held across 10 cycles of toggling br_taken_exe, then resume.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    cycle_check("halt enter", ST, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 0, 1'b0, 1'b0, 1'b0);
      cycle_check($sformatf("halted%0d", i), ST, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cycle_check("resume", ST, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle_check("after resume", P4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted inside the flush window.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cycle_check("mf branch", BR, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mf flush", P4, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mf reset", ST, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    check_perf_zero("perf after reset");
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_sequence("re");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
